// File: rtl/input_stream_loader.sv
// Host-side stimulus loader for the switch input ports.
// The CPU fills one RAM per port over an Avalon-MM slave, then starts playback.
// Each port then streams its words out with a valid/ready handshake.
// The output register of each port doubles as the RAM read register, so a
// word fetched in one cycle is presented on inp in the next.
module input_stream_loader #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           chipselect,
    input  logic                           write,
    input  logic                           read,
    input  logic [3:0]                     address,
    input  logic [31:0]                    writedata,
    output logic [31:0]                    readdata,
    output logic [NPORTS-1:0][DATA_W-1:0]  inp,
    output logic [NPORTS-1:0]              in_valid,
    input  logic [NPORTS-1:0]              in_ready,
    output logic                           done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // wcnt: words stored, fcnt: words fetched from RAM, rptr: words accepted by the switch
    logic [NPORTS-1:0][CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [NPORTS-1:0][CNT_W-1:0]  fcnt_q, fcnt_d;
    logic [NPORTS-1:0][CNT_W-1:0]  rptr_q, rptr_d;
    logic [NPORTS-1:0]             ovf_q, ovf_d;
    logic [NPORTS-1:0]             vld_q, vld_d;
    logic [NPORTS-1:0][DATA_W-1:0] inp_q;
    logic [31:0]                   readdata_q, rd_mux;

    logic [NPORTS-1:0] push_req, push_ok, load;
    logic              wr_en, rd_en, start_req, clear_req, all_drained;

    logic [DATA_W-1:0] mem [NPORTS][DEPTH];

    assign wr_en     = chipselect & write;
    assign rd_en     = chipselect & read;
    assign start_req = wr_en && (address == 4'd4) && writedata[0];
    assign clear_req = wr_en && (address == 4'd4) && writedata[1];

    // Decode host pushes; a push is only stored while idle and not full
    always_comb begin
        push_req = '0;
        push_ok  = '0;
        for (int n = 0; n < NPORTS; n++) begin
            push_req[n] = wr_en && (address == 4'(n));
            push_ok[n]  = push_req[n] && (state_q == S_IDLE) && (wcnt_q[n] != FULL);
        end
    end

    // Per-port counters and output-register control; fetch whenever the output slot frees up
    always_comb begin
        wcnt_d = wcnt_q;
        fcnt_d = fcnt_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        vld_d  = vld_q;
        load   = '0;
        for (int n = 0; n < NPORTS; n++) begin
            load[n] = (state_q == S_RUN) && (!vld_q[n] || in_ready[n]) &&
                      (fcnt_q[n] != wcnt_q[n]) && !clear_req;
            if (push_req[n]) begin
                if (push_ok[n]) wcnt_d[n] = wcnt_q[n] + CNT_W'(1);
                else            ovf_d[n]  = 1'b1;
            end
            if (vld_q[n] && in_ready[n]) rptr_d[n] = rptr_q[n] + CNT_W'(1);
            if (load[n]) begin
                fcnt_d[n] = fcnt_q[n] + CNT_W'(1);
                vld_d[n]  = 1'b1;
            end else if (vld_q[n] && in_ready[n]) begin
                vld_d[n]  = 1'b0;
            end
        end
        if (clear_req) begin
            wcnt_d = '0;
            fcnt_d = '0;
            rptr_d = '0;
            ovf_d  = '0;
            vld_d  = '0;
        end
    end

    // Next state; drain is judged on next-cycle values so done rises right after the last transfer
    always_comb begin
        all_drained = 1'b1;
        for (int n = 0; n < NPORTS; n++) begin
            if ((rptr_d[n] != wcnt_d[n]) || vld_d[n]) all_drained = 1'b0;
        end
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_RUN;
            S_RUN:   if (all_drained) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (clear_req) state_d = S_IDLE;
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            fcnt_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            fcnt_q  <= fcnt_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    // RAM write port: accepted pushes land at the current word count
    always_ff @(posedge clk) begin
        for (int n = 0; n < NPORTS; n++) begin
            if (push_ok[n]) mem[n][wcnt_q[n][ADDR_W-1:0]] <= writedata[DATA_W-1:0];
        end
    end

    // RAM read port feeding the per-port output register; held while the switch stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            inp_q <= '0;
        end else begin
            for (int n = 0; n < NPORTS; n++) begin
                if (clear_req)    inp_q[n] <= '0;
                else if (load[n]) inp_q[n] <= mem[n][fcnt_q[n][ADDR_W-1:0]];
            end
        end
    end

    // Status read multiplexer
    always_comb begin
        rd_mux = 32'hFF;
        case (address)
            4'd0, 4'd1, 4'd2, 4'd3:  rd_mux = 32'(wcnt_q[address[1:0]]);
            4'd4:                    rd_mux = 32'(ovf_q);
            4'd5:                    rd_mux = 32'(state_q);
            4'd8, 4'd9, 4'd10, 4'd11: rd_mux = 32'(rptr_q[address[1:0]]);
            default:                 rd_mux = 32'hFF;
        endcase
    end

    // Registered read data; keeps the last value when no read is issued
    always_ff @(posedge clk) begin
        if (reset)      readdata_q <= '0;
        else if (rd_en) readdata_q <= rd_mux;
    end

    assign readdata = readdata_q;
    assign inp      = inp_q;
    assign in_valid = vld_q;
    assign done     = (state_q == S_DONE);

endmodule
